decode_stage_pipe: RTL and testbench

//  Parametrised decode stage for the pipelined 16-bit CPU. Splits the instruction into

---
 rtl/decode_stage_pipe_pkg.sv | 36 +++
 rtl/decode_stage_pipe_if.sv | 38 +++
 rtl/decode_stage_pipe_reg_file.sv | 39 +++
 rtl/decode_stage_pipe.sv | 82 ++++++++
 tb/tb_decode_stage_pipe.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pipe_pkg.sv
// Shared decode definitions: default widths, field positions, opcodes and sign extension.
// Imported by the decode stage and its register file.
package decode_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_RADDR_W = 4;
    localparam int DEF_OPC_W   = 4;

    typedef enum logic [3:0] {
        OPC_ADD    = 4'h0,
        OPC_SUB    = 4'h1,
        OPC_AND    = 4'h2,
        OPC_OR     = 4'h3,
        OPC_XOR    = 4'h4,
        OPC_LOAD   = 4'hA,
        OPC_STORE  = 4'hB,
        OPC_BRANCH = 4'hC
    } opcode_t;

    // Field LSB positions; dest occupies the low RADDR_W bits.
    function automatic int src2Lsb(input int raddrW);
        return raddrW;
    endfunction

    function automatic int src1Lsb(input int raddrW);
        return 2 * raddrW;
    endfunction

    // Sign-extend the low w bits of v to 32 bits.
    function automatic logic [31:0] sext(input logic [31:0] v, input int unsigned w);
        logic [31:0] s;
        s = v << (32 - w);
        return $signed(s) >>> (32 - w);
    endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Decode-stage bus: IF/ID inputs, write-back port, hazard/branch outputs and D/E register.
// master = fetch/write-back side, slave = decode stage.
interface decode_stage_pipe_if #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 4,
    parameter int OPC_W   = 4
);
    localparam int INST_W = OPC_W + 3 * RADDR_W;

    logic [INST_W-1:0]  inst_d;
    logic [DATA_W-1:0]  pc_d;
    logic               valid_d;
    logic               imm_sel;
    logic               flush;
    logic               wb_en;
    logic [RADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0]  wb_data;
    logic               stall_d;
    logic [DATA_W-1:0]  pc_branch;
    logic [OPC_W-1:0]   opcode_e;
    logic [RADDR_W-1:0] dest_e;
    logic [RADDR_W-1:0] src1_e;
    logic [RADDR_W-1:0] src2_e;
    logic [DATA_W-1:0]  op1_e;
    logic [DATA_W-1:0]  op2_e;
    logic               valid_e;

    modport master (
        output inst_d, pc_d, valid_d, imm_sel, flush, wb_en, wb_addr, wb_data,
        input  stall_d, pc_branch, opcode_e, dest_e, src1_e, src2_e, op1_e, op2_e, valid_e
    );

    modport slave (
        input  inst_d, pc_d, valid_d, imm_sel, flush, wb_en, wb_addr, wb_data,
        output stall_d, pc_branch, opcode_e, dest_e, src1_e, src2_e, op1_e, op2_e, valid_e
    );

endinterface

// File: rtl/decode_stage_pipe_reg_file.sv
// 2-read/1-write register file with write-to-read bypass; reads combinational, writes on clk.
// No backpressure: a write is accepted every cycle wrEn is high.
module reg_file_bypass #(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 4,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wrEn,
    input  logic [RADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0]  wrData,
    input  logic [RADDR_W-1:0] rdAddrA,
    output logic [DATA_W-1:0]  rdDataA,
    input  logic [RADDR_W-1:0] rdAddrB,
    output logic [DATA_W-1:0]  rdDataB
);
    localparam int NUM_REGS = 2 ** RADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wrAllowed;

    assign wrAllowed = wrEn && !(ZERO_R0 && wrAddr == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wrAllowed) begin
            regs[wrAddr] <= wrData;
        end
    end

    // r0 is hard zero and must not pick up a bypassed write.
    assign rdDataA = (ZERO_R0 && rdAddrA == '0)  ? '0     :
                     (wrEn && wrAddr == rdAddrA) ? wrData : regs[rdAddrA];
    assign rdDataB = (ZERO_R0 && rdAddrB == '0)  ? '0     :
                     (wrEn && wrAddr == rdAddrB) ? wrData : regs[rdAddrB];

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: field split, register read, branch target, load-use stall, D/E register.
// One cycle to *_e; stall_d/pc_branch are combinational; flush beats stall beats capture.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter int               DATA_W   = DEF_DATA_W,
    parameter int               RADDR_W  = DEF_RADDR_W,
    parameter int               OPC_W    = DEF_OPC_W,
    parameter bit               ZERO_R0  = 1'b1,
    parameter logic [OPC_W-1:0] LOAD_OPC = OPC_LOAD
) (
    input  logic              clk,
    input  logic              reset,
    decode_stage_pipe_if.slave bus
);
    localparam int INST_W   = OPC_W + 3 * RADDR_W;
    localparam int SRC1_LSB = src1Lsb(RADDR_W);
    localparam int SRC2_LSB = src2Lsb(RADDR_W);

    logic [OPC_W-1:0]   opcode;
    logic [RADDR_W-1:0] src1;
    logic [RADDR_W-1:0] src2;
    logic [RADDR_W-1:0] dest;
    logic [DATA_W-1:0]  rdData1;
    logic [DATA_W-1:0]  rdData2;
    logic [DATA_W-1:0]  op2Next;
    logic               loadInE;
    logic               srcMatch;

    assign opcode = bus.inst_d[INST_W-1 -: OPC_W];
    assign src1   = bus.inst_d[SRC1_LSB +: RADDR_W];
    assign src2   = bus.inst_d[SRC2_LSB +: RADDR_W];
    assign dest   = bus.inst_d[RADDR_W-1:0];

    reg_file_bypass #(
        .DATA_W (DATA_W),
        .RADDR_W(RADDR_W),
        .ZERO_R0(ZERO_R0)
    ) u_regFile (
        .clk    (clk),
        .reset  (reset),
        .wrEn   (bus.wb_en),
        .wrAddr (bus.wb_addr),
        .wrData (bus.wb_data),
        .rdAddrA(src1),
        .rdDataA(rdData1),
        .rdAddrB(src2),
        .rdDataB(rdData2)
    );

    assign op2Next       = bus.imm_sel ? DATA_W'(sext(32'(src2), RADDR_W)) : rdData2;
    assign bus.pc_branch = bus.pc_d + DATA_W'(sext(32'(dest), RADDR_W));

    // A load targeting r0 never produces a value, so it cannot cause a hazard.
    assign loadInE    = bus.valid_e && bus.opcode_e == LOAD_OPC &&
                        !(ZERO_R0 && bus.dest_e == '0);
    assign srcMatch   = (bus.dest_e == src1) || (bus.dest_e == src2 && !bus.imm_sel);
    assign bus.stall_d = bus.valid_d && loadInE && srcMatch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.opcode_e <= '0;
            bus.dest_e   <= '0;
            bus.src1_e   <= '0;
            bus.src2_e   <= '0;
            bus.op1_e    <= '0;
            bus.op2_e    <= '0;
            bus.valid_e  <= 1'b0;
        end else if (bus.flush || bus.stall_d) begin
            bus.valid_e <= 1'b0;
        end else begin
            bus.opcode_e <= opcode;
            bus.dest_e   <= dest;
            bus.src1_e   <= src1;
            bus.src2_e   <= src2;
            bus.op1_e    <= rdData1;
            bus.op2_e    <= op2Next;
            bus.valid_e  <= bus.valid_d;
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Randomised and directed bench for decode_stage_pipe against an arithmetic reference model.
module tb_decode_stage_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_stage_pipe_if #(.DATA_W(16), .RADDR_W(4), .OPC_W(4)) bus ();

    decode_stage_pipe #(
        .DATA_W(16), .RADDR_W(4), .OPC_W(4), .ZERO_R0(1'b1), .LOAD_OPC(4'hA)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: architectural registers and the instruction held in E.
    int mRegs [16];
    bit mValid;
    int mOpc, mDest, mSrc1, mSrc2, mOp1, mOp2;
    logic [31:0] lastStall, lastBr;

    function automatic int sx4(input int v);
        return (v >= 8) ? v - 16 : v;
    endfunction

    function automatic int readModel(input int a, input bit we, input int wa, input int wd);
        if (a == 0) return 0;
        if (we && wa == a) return wd;
        return mRegs[a];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkE();
        chk("valid_e", 32'(bus.valid_e), 32'(mValid));
        if (mValid) begin
            chk("opcode_e", 32'(bus.opcode_e), 32'(mOpc));
            chk("dest_e",   32'(bus.dest_e),   32'(mDest));
            chk("src1_e",   32'(bus.src1_e),   32'(mSrc1));
            chk("src2_e",   32'(bus.src2_e),   32'(mSrc2));
            chk("op1_e",    32'(bus.op1_e),    32'(mOp1));
            chk("op2_e",    32'(bus.op2_e),    32'(mOp2));
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < 16; i++) mRegs[i] = 0;
        mValid = 1'b0;
        mOpc = 0; mDest = 0; mSrc1 = 0; mSrc2 = 0; mOp1 = 0; mOp2 = 0;
    endtask

    // One clock: drive, check combinational outputs, advance model, check D/E.
    task automatic step(input int opc, input int s1, input int s2, input int d, input int pc,
                        input bit vd, input bit imm, input bit fl,
                        input bit we, input int wa, input int wd);
        bit expStall;
        int expBr;
        @(negedge clk);
        bus.inst_d  = 16'((opc << 12) | (s1 << 8) | (s2 << 4) | d);
        bus.pc_d    = 16'(pc);
        bus.valid_d = vd;
        bus.imm_sel = imm;
        bus.flush   = fl;
        bus.wb_en   = we;
        bus.wb_addr = 4'(wa);
        bus.wb_data = 16'(wd);
        #1;
        expStall = vd && mValid && mOpc == 10 && mDest != 0 &&
                   (mDest == s1 || (mDest == s2 && !imm));
        expBr    = (pc + sx4(d)) & 'hFFFF;
        lastStall = 32'(bus.stall_d);
        lastBr    = 32'(bus.pc_branch);
        chk("stall_d",   lastStall, 32'(expStall));
        chk("pc_branch", lastBr,    32'(expBr));
        if (fl || expStall) begin
            mValid = 1'b0;
        end else begin
            mValid = vd;
            mOpc = opc; mDest = d; mSrc1 = s1; mSrc2 = s2;
            mOp1 = readModel(s1, we, wa, wd);
            mOp2 = imm ? (sx4(s2) & 'hFFFF) : readModel(s2, we, wa, wd);
        end
        if (we && wa != 0) mRegs[wa] = wd;
        @(posedge clk);
        #1;
        checkE();
    endtask

    initial begin
        bus.inst_d = '0; bus.pc_d = '0; bus.valid_d = 1'b0; bus.imm_sel = 1'b0;
        bus.flush = 1'b0; bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        clearModel();
        reset = 1'b1;
        #3;
        checkE();
        chk("reset_op1", 32'(bus.op1_e), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Write-back bypass into the same-cycle read.
        step(0, 3, 0, 1, 16'h0100, 1, 0, 0, 1, 3, 16'h1234);
        chk("bypass_op1", 32'(bus.op1_e), 32'h1234);

        // Load-use on src2, then the same consumer proceeds after one bubble.
        step(10, 1, 1, 2, 16'h0102, 1, 0, 0, 0, 0, 0);
        step(0, 1, 2, 4, 16'h0104, 1, 0, 0, 0, 0, 0);
        chk("hazard_stall", lastStall, 32'h1);
        chk("hazard_bubble", 32'(bus.valid_e), 32'h0);
        step(0, 1, 2, 4, 16'h0104, 1, 0, 0, 0, 0, 0);
        chk("after_bubble_stall", lastStall, 32'h0);

        // Immediate operand masks the src2 match.
        step(10, 1, 1, 2, 16'h0106, 1, 0, 0, 0, 0, 0);
        step(0, 1, 2, 4, 16'h0108, 1, 1, 0, 0, 0, 0);
        chk("imm_no_stall", lastStall, 32'h0);
        chk("imm_valid", 32'(bus.valid_e), 32'h1);
        chk("imm_op2", 32'(bus.op2_e), 32'h0002);

        // Flush together with a stall, then flush alone.
        step(10, 1, 1, 2, 16'h010A, 1, 0, 0, 0, 0, 0);
        step(0, 2, 1, 4, 16'h010C, 1, 0, 1, 0, 0, 0);
        chk("flush_stall_stall", lastStall, 32'h1);
        chk("flush_stall_valid", 32'(bus.valid_e), 32'h0);
        step(0, 1, 1, 4, 16'h010E, 1, 0, 1, 0, 0, 0);
        chk("flush_only_valid", 32'(bus.valid_e), 32'h0);

        // Branch target wrap-around and negative offset.
        step(1, 1, 1, 3, 16'hFFFE, 1, 0, 0, 0, 0, 0);
        chk("branch_wrap", lastBr, 32'h0001);
        step(1, 1, 1, 15, 16'hFFFE, 1, 0, 0, 0, 0, 0);
        chk("branch_neg", lastBr, 32'hFFFD);

        // r0 ignores writes and reads as zero.
        step(0, 1, 1, 1, 16'h0200, 0, 0, 0, 1, 0, 16'hBEEF);
        step(0, 0, 0, 1, 16'h0202, 1, 0, 0, 0, 0, 0);
        chk("r0_op1", 32'(bus.op1_e), 32'h0);

        for (int n = 0; n < 400; n++) begin
            int opc, s1, s2, d, wa;
            opc = ($urandom_range(0, 2) == 0) ? 10 : int'($urandom_range(0, 15));
            s1  = int'($urandom_range(0, 4));
            s2  = int'($urandom_range(0, 4));
            d   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 4));
            wa  = int'($urandom_range(0, 5));
            step(opc, s1, s2, d, int'($urandom_range(0, 16'hFFFF)),
                 $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
                 wa, int'($urandom_range(0, 16'hFFFF)));
        end

        // Asynchronous reset while E holds a valid instruction.
        step(0, 1, 1, 1, 16'h0300, 0, 0, 0, 1, 5, 16'h5555);
        step(0, 5, 5, 1, 16'h0302, 1, 0, 0, 0, 0, 0);
        chk("pre_reset_valid", 32'(bus.valid_e), 32'h1);
        chk("pre_reset_r5", 32'(bus.op1_e), 32'h5555);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        clearModel();
        chk("rst_valid_e",  32'(bus.valid_e),  32'h0);
        chk("rst_opcode_e", 32'(bus.opcode_e), 32'h0);
        chk("rst_dest_e",   32'(bus.dest_e),   32'h0);
        chk("rst_src1_e",   32'(bus.src1_e),   32'h0);
        chk("rst_src2_e",   32'(bus.src2_e),   32'h0);
        chk("rst_op1_e",    32'(bus.op1_e),    32'h0);
        chk("rst_op2_e",    32'(bus.op2_e),    32'h0);
        @(negedge clk);
        reset = 1'b0;
        step(0, 5, 5, 1, 16'h0304, 1, 0, 0, 0, 0, 0);
        chk("r5_after_reset", 32'(bus.op1_e), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
